// File: rtl/led_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : led_uart_rx
// Description : 8N1 serial receiver with a valid/ready byte output, a two-flop
//               input synchronizer, and framing-error / overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================

module led_uart_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_sync1;
   logic             r_sync2;
   logic             w_rx_s;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [2:0]       r_idx;
   logic [2:0]       w_idx_nxt;
   logic [7:0]       r_shift;
   logic [7:0]       w_shift_nxt;
   logic             w_done;
   logic             w_ferr;
   logic [7:0]       r_data;
   logic             r_valid;
   logic             r_frame_err;
   logic             r_overrun;

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rx_s = r_sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_idx   <= 3'd0;
         r_shift <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + c_cnt_one;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_done      = 1'b0;
      w_ferr      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (!w_rx_s) begin
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            // Mid-start-bit recheck rejects short glitches silently.
            if (r_cnt == c_half_last) begin
               w_cnt_nxt   = '0;
               w_idx_nxt   = 3'd0;
               w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (r_cnt == c_bit_last) begin
               w_cnt_nxt   = '0;
               w_shift_nxt = {w_rx_s, r_shift[7:1]};
               w_idx_nxt   = r_idx + 3'd1;
               if (r_idx == 3'd7) begin
                  w_state_nxt = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            // Leaving at mid-stop-bit leaves half a bit of slack for the next start edge.
            if (r_cnt == c_bit_last) begin
               w_cnt_nxt = '0;
               if (w_rx_s) begin
                  w_done      = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_ferr      = 1'b1;
                  w_state_nxt = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            w_cnt_nxt = '0;
            if (w_rx_s) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Holding register: a completed byte loads only if the slot is empty or
   // being drained on this same edge; otherwise it is dropped and flagged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data      <= 8'd0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_ferr;
         r_overrun   <= w_done && r_valid && !rx_ready;
         if (w_done && (!r_valid || rx_ready)) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rx_data   = r_data;
   assign rx_valid  = r_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_led_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_uart_rx
// Description : Scoreboard bench for led_uart_rx with directed and random frames.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_led_uart_rx;

   localparam int CPB = 16;
   localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   led_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      int         t;
      bit         lat;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   ferr_cnt = 0;
   int   ovr_cnt = 0;
   int   busy_seen = 0;
   int   exp_ferr = 0;
   int   exp_ovr = 0;
   bit   hold_full = 0;

   task automatic chk(input string nm, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, expv, expv, cyc);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d..%0d at cycle %0d", nm, act, lo, hi, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
      if (busy)      busy_seen++;
   end

   // Monitor: every accepted beat must match the oldest expected byte.
   always @(negedge clk) begin
      if (rst_n && rx_valid && rx_ready) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got data 0x%0h with empty scoreboard at cycle %0d",
                     rx_data, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("beat_data", int'(rx_data), int'(e.d));
            if (e.lat) chk_rng("beat_latency", cyc - e.t, LAT - 2, LAT + 2);
         end
      end
   end

   task automatic bitwait();
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: a good frame is delivered unless a stalled consumer
   // already holds a byte, in which case it is lost and counts as an overrun.
   task automatic send(input logic [7:0] b, input logic stop, input bit lat);
      exp_t e;
      e.d   = b;
      e.t   = cyc;
      e.lat = lat;
      if (stop) begin
         if (!hold_full) begin
            q.push_back(e);
            if (!rx_ready) hold_full = 1;
         end else begin
            exp_ovr++;
         end
      end else begin
         exp_ferr++;
      end
      rx = 1'b0;
      bitwait();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         bitwait();
      end
      rx = stop;
      bitwait();
   endtask

   initial begin
      logic [7:0] c3;
      logic [7:0] rb;
      int         gap;
      bit         good;
      int         waited;

      rst_n    = 1'b0;
      rx       = 1'b1;
      rx_ready = 1'b1;
      #5;
      chk("reset_valid", int'(rx_valid), 0);
      chk("reset_data", int'(rx_data), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_frame_err", int'(frame_err), 0);
      chk("reset_overrun", int'(overrun), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      busy_seen = 0;
      idle(1000);
      chk("idle_busy_seen", busy_seen, 0);
      chk("idle_valid", int'(rx_valid), 0);
      chk("idle_ferr", ferr_cnt, 0);
      chk("idle_ovr", ovr_cnt, 0);

      send(8'hA5, 1'b1, 1'b1);
      idle(20);
      chk("single_valid_dropped", int'(rx_valid), 0);
      chk("single_drained", q.size(), 0);

      send(8'h00, 1'b1, 1'b1);
      send(8'hFF, 1'b1, 1'b1);
      send(8'h3C, 1'b1, 1'b1);
      idle(20);
      chk("b2b_drained", q.size(), 0);

      rx_ready  = 1'b0;
      hold_full = 0;
      send(8'h11, 1'b1, 1'b0);
      send(8'h22, 1'b1, 1'b0);
      idle(20);
      chk("ovr_valid_held", int'(rx_valid), 1);
      chk("ovr_data_held", int'(rx_data), 'h11);
      chk("ovr_pulses", ovr_cnt, exp_ovr);
      rx_ready  = 1'b1;
      hold_full = 0;
      idle(5);
      chk("ovr_valid_released", int'(rx_valid), 0);
      chk("ovr_drained", q.size(), 0);

      send(8'h55, 1'b0, 1'b0);
      repeat (50) @(posedge clk);
      #1;
      chk("break_busy", int'(busy), 1);
      chk("break_ferr", ferr_cnt, exp_ferr);
      idle(10);
      chk("break_exit", int'(busy), 0);
      send(8'h55, 1'b1, 1'b1);
      idle(20);
      chk("after_break_drained", q.size(), 0);

      rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      idle(50);
      chk("glitch_busy", int'(busy), 0);
      chk("glitch_ferr", ferr_cnt, exp_ferr);
      chk("glitch_valid", int'(rx_valid), 0);

      // Async reset in the middle of bit 4, away from any clock edge.
      c3 = 8'hC3;
      rx = 1'b0;
      bitwait();
      for (int i = 0; i < 4; i++) begin
         rx = c3[i];
         bitwait();
      end
      rx = c3[4];
      repeat (5) @(posedge clk);
      #5;
      chk("midframe_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("async_busy", int'(busy), 0);
      chk("async_valid", int'(rx_valid), 0);
      chk("async_data", int'(rx_data), 0);
      chk("async_ferr", int'(frame_err), 0);
      rx = 1'b1;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(40);
      send(8'h7E, 1'b1, 1'b1);
      idle(20);
      chk("after_reset_drained", q.size(), 0);

      for (int n = 0; n < 24; n++) begin
         rb   = 8'($urandom);
         good = ($urandom_range(0, 5) != 0);
         send(rb, good, 1'b1);
         gap = int'($urandom_range(0, 30));
         if (!good && gap < 4) gap = 4;
         if (gap > 0) idle(gap);
      end
      idle(20);

      waited = 0;
      while (q.size() != 0 && waited < 2000) begin
         @(posedge clk);
         waited++;
      end
      #1;
      chk("final_drained", q.size(), 0);
      chk("final_ferr", ferr_cnt, exp_ferr);
      chk("final_ovr", ovr_cnt, exp_ovr);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
